// File: rtl/pll_lock_sequencer.sv
// Power-up sequencer for the memory PLL and the DDR controller.
// It holds the PLL in reset, waits for a stable lock, releases the memory
// controller reset and waits for calibration before it raises ready_o.
// A lost lock or a calibration timeout is retried a bounded number of
// times. After that the block stays in FAIL until rst_n is pulsed.
//
// Handshake/flag semantics: pll_lock_i and calib_done_i are level flags,
// asynchronous to clk. Each one passes through a SYNC_STAGES-deep
// synchroniser, and the FSM acts only on the synchronised copies.
// The outputs are levels and are all registered. They change on the same
// edge as the state they belong to.
//
// Cycle accounting: cnt counts the cycles already spent in the current
// state and clears on every transition.
//   PLL_RST stays for exactly PLL_RST_CYCLES cycles.
//   STABLE needs LOCK_STABLE_CYCLES cycles in which lock_s is seen high.
//   WAIT_LOCK and CALIB give up after TIMEOUT_CYCLES cycles.
module pll_lock_sequencer #(
  parameter int SYNC_STAGES        = 2,
  parameter int PLL_RST_CYCLES     = 16,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int TIMEOUT_CYCLES     = 4194304,
  parameter int MAX_RETRIES        = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock_i,
  input  logic       calib_done_i,
  output logic       pll_rst_o,
  output logic       mem_rst_n_o,
  output logic       ready_o,
  output logic       fail_o,
  output logic [1:0] retry_cnt_o,
  output logic [2:0] state_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    CALIB     = 3'd3,
    READY     = 3'd4,
    FAIL      = 3'd5
  } state_t;

  logic [SYNC_STAGES-1:0] lock_sync;
  logic [SYNC_STAGES-1:0] calib_sync;
  logic                   lock_s;
  logic                   calib_s;

  state_t          state;
  state_t          state_n;
  logic [1:0]      retry_cnt;
  logic [1:0]      retry_n;
  logic [CW-1:0]   cnt;
  logic            timeout;
  logic            fail_attempt;

  assign lock_s  = lock_sync[SYNC_STAGES-1];
  assign calib_s = calib_sync[SYNC_STAGES-1];
  assign timeout = (cnt >= CW'(TIMEOUT_CYCLES - 1));

  // Bring the two asynchronous status flags into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_sync  <= '0;
      calib_sync <= '0;
    end else begin
      lock_sync  <= {lock_sync[SYNC_STAGES-2:0], pll_lock_i};
      calib_sync <= {calib_sync[SYNC_STAGES-2:0], calib_done_i};
    end
  end

  // Next-state and retry decision. Lock loss has priority over calib
  // done, and calib done has priority over a timeout.
  always_comb begin
    state_n      = state;
    retry_n      = retry_cnt;
    fail_attempt = 1'b0;
    case (state)
      PLL_RST: begin
        if (cnt >= CW'(PLL_RST_CYCLES - 1)) state_n = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (lock_s)       state_n = STABLE;
        else if (timeout) fail_attempt = 1'b1;
      end
      STABLE: begin
        if (!lock_s)                                    state_n = WAIT_LOCK;
        else if (cnt >= CW'(LOCK_STABLE_CYCLES - 1))    state_n = CALIB;
      end
      CALIB: begin
        if (!lock_s)      fail_attempt = 1'b1;
        else if (calib_s) state_n = READY;
        else if (timeout) fail_attempt = 1'b1;
      end
      READY: begin
        if (!lock_s || !calib_s) state_n = PLL_RST;
      end
      FAIL: begin
        state_n = FAIL;
      end
      default: begin
        state_n = PLL_RST;
      end
    endcase
    if (fail_attempt) begin
      retry_n = retry_cnt + 2'd1;
      state_n = (int'(retry_cnt) < MAX_RETRIES - 1) ? PLL_RST : FAIL;
    end
    if (state_n == READY) retry_n = 2'd0;
  end

  // State, shared counter and registered outputs, all derived from state_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= PLL_RST;
      retry_cnt   <= 2'd0;
      cnt         <= '0;
      pll_rst_o   <= 1'b1;
      mem_rst_n_o <= 1'b0;
      ready_o     <= 1'b0;
      fail_o      <= 1'b0;
    end else begin
      state     <= state_n;
      retry_cnt <= retry_n;
      if (state_n != state) cnt <= '0;
      else if (cnt != '1)   cnt <= cnt + CW'(1);
      pll_rst_o   <= (state_n == PLL_RST) || (state_n == FAIL);
      mem_rst_n_o <= (state_n == CALIB) || (state_n == READY);
      ready_o     <= (state_n == READY);
      fail_o      <= (state_n == FAIL);
    end
  end

  assign state_o     = state;
  assign retry_cnt_o = retry_cnt;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer. It uses short parameters:
// PLL reset 4 cycles, stable window 8 cycles, timeout 64 cycles,
// 3 retries and a 2-stage synchroniser.
// Inputs are driven, and outputs sampled, 1 ns after the rising clock edge.
module tb_pll_lock_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_lock_i;
  logic       calib_done_i;
  logic       pll_rst_o;
  logic       mem_rst_n_o;
  logic       ready_o;
  logic       fail_o;
  logic [1:0] retry_cnt_o;
  logic [2:0] state_o;

  int vectors     = 0;
  int miscompares = 0;

  pll_lock_sequencer #(
    .SYNC_STAGES       (2),
    .PLL_RST_CYCLES    (4),
    .LOCK_STABLE_CYCLES(8),
    .TIMEOUT_CYCLES    (64),
    .MAX_RETRIES       (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pll_lock_i  (pll_lock_i),
    .calib_done_i(calib_done_i),
    .pll_rst_o   (pll_rst_o),
    .mem_rst_n_o (mem_rst_n_o),
    .ready_o     (ready_o),
    .fail_o      (fail_o),
    .retry_cnt_o (retry_cnt_o),
    .state_o     (state_o)
  );

  // 50 MHz board clock
  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_all(input string tag, input logic [2:0] st, input logic pr,
                            input logic mr, input logic rdy, input logic fl,
                            input logic [1:0] rc);
    chk($sformatf("%s.state", tag),     {5'b0, state_o},     {5'b0, st});
    chk($sformatf("%s.pll_rst", tag),   {7'b0, pll_rst_o},   {7'b0, pr});
    chk($sformatf("%s.mem_rst_n", tag), {7'b0, mem_rst_n_o}, {7'b0, mr});
    chk($sformatf("%s.ready", tag),     {7'b0, ready_o},     {7'b0, rdy});
    chk($sformatf("%s.fail", tag),      {7'b0, fail_o},      {7'b0, fl});
    chk($sformatf("%s.retry", tag),     {6'b0, retry_cnt_o}, {6'b0, rc});
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n        = 1'b0;
    pll_lock_i   = 1'b0;
    calib_done_i = 1'b0;
    step(3);
    expect_all("reset", 3'd0, 1, 0, 0, 0, 2'd0);

    // Nominal power-up, lock high from release
    rst_n      = 1'b1;
    pll_lock_i = 1'b1;
    step(3);  expect_all("nom_pllrst",    3'd0, 1, 0, 0, 0, 2'd0);
    step(1);  expect_all("nom_waitlock",  3'd1, 0, 0, 0, 0, 2'd0);
    step(1);  expect_all("nom_stable",    3'd2, 0, 0, 0, 0, 2'd0);
    step(7);  expect_all("nom_stable_end",3'd2, 0, 0, 0, 0, 2'd0);
    step(1);  expect_all("nom_calib",     3'd3, 0, 1, 0, 0, 2'd0);
    calib_done_i = 1'b1;
    step(2);  expect_all("nom_calib_sync",3'd3, 0, 1, 0, 0, 2'd0);
    step(1);  expect_all("nom_ready",     3'd4, 0, 1, 1, 0, 2'd0);

    // Lock loss while ready
    pll_lock_i = 1'b0;
    step(2);  expect_all("rdy_hold",      3'd4, 0, 1, 1, 0, 2'd0);
    step(1);  expect_all("rdy_lost",      3'd0, 1, 0, 0, 0, 2'd0);
    pll_lock_i = 1'b1;
    step(4);  expect_all("rdy_rewait",    3'd1, 0, 0, 0, 0, 2'd0);
    step(1);  expect_all("rdy_restable",  3'd2, 0, 0, 0, 0, 2'd0);
    step(8);  expect_all("rdy_recalib",   3'd3, 0, 1, 0, 0, 2'd0);
    step(1);  expect_all("rdy_reready",   3'd4, 0, 1, 1, 0, 2'd0);

    // Lock glitch in STABLE at stable count 5
    rst_n        = 1'b0;
    calib_done_i = 1'b0;
    pll_lock_i   = 1'b0;
    #1;       expect_all("glitch_rst",    3'd0, 1, 0, 0, 0, 2'd0);
    step(1);
    rst_n      = 1'b1;
    pll_lock_i = 1'b1;
    step(5);  expect_all("glitch_stable", 3'd2, 0, 0, 0, 0, 2'd0);
    step(5);
    pll_lock_i = 1'b0;
    step(2);  expect_all("glitch_lag",    3'd2, 0, 0, 0, 0, 2'd0);
    step(1);  expect_all("glitch_back",   3'd1, 0, 0, 0, 0, 2'd0);
    pll_lock_i = 1'b1;
    step(2);  expect_all("glitch_wait",   3'd1, 0, 0, 0, 0, 2'd0);
    step(1);  expect_all("glitch_relock", 3'd2, 0, 0, 0, 0, 2'd0);
    step(7);  expect_all("glitch_full",   3'd2, 0, 0, 0, 0, 2'd0);
    step(1);  expect_all("glitch_calib",  3'd3, 0, 1, 0, 0, 2'd0);

    // Calibration timeout, then a successful second attempt
    step(63); expect_all("to_last",       3'd3, 0, 1, 0, 0, 2'd0);
    step(1);  expect_all("to_retry",      3'd0, 1, 0, 0, 0, 2'd1);
    step(3);  expect_all("to_pllrst",     3'd0, 1, 0, 0, 0, 2'd1);
    step(1);  expect_all("to_wait",       3'd1, 0, 0, 0, 0, 2'd1);
    step(1);  expect_all("to_stable",     3'd2, 0, 0, 0, 0, 2'd1);
    step(8);  expect_all("to_calib",      3'd3, 0, 1, 0, 0, 2'd1);
    calib_done_i = 1'b1;
    step(3);  expect_all("to_ready",      3'd4, 0, 1, 1, 0, 2'd0);

    // Calibration flag dropping while ready
    calib_done_i = 1'b0;
    step(2);  expect_all("cal_drop_hold", 3'd4, 0, 1, 1, 0, 2'd0);
    step(1);  expect_all("cal_drop",      3'd0, 1, 0, 0, 0, 2'd0);

    // Exhaustion: lock never arrives
    rst_n      = 1'b0;
    pll_lock_i = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(68); expect_all("ex_retry1",     3'd0, 1, 0, 0, 0, 2'd1);
    step(68); expect_all("ex_retry2",     3'd0, 1, 0, 0, 0, 2'd2);
    step(67); expect_all("ex_last",       3'd1, 0, 0, 0, 0, 2'd2);
    step(1);  expect_all("ex_fail",       3'd5, 1, 0, 0, 1, 2'd3);
    pll_lock_i   = 1'b1;
    calib_done_i = 1'b1;
    step(40); expect_all("ex_sticky",     3'd5, 1, 0, 0, 1, 2'd3);
    rst_n = 1'b0;
    #1;       expect_all("ex_clear",      3'd0, 1, 0, 0, 0, 2'd0);
    step(1);
    rst_n        = 1'b1;
    calib_done_i = 1'b0;

    // Async reset in the middle of CALIB, then a nominal restart
    step(13); expect_all("ar_calib",      3'd3, 0, 1, 0, 0, 2'd0);
    step(10); expect_all("ar_mid",        3'd3, 0, 1, 0, 0, 2'd0);
    rst_n = 1'b0;
    #1;       expect_all("ar_reset",      3'd0, 1, 0, 0, 0, 2'd0);
    #2;
    rst_n = 1'b1;
    step(3);  expect_all("ar_pllrst",     3'd0, 1, 0, 0, 0, 2'd0);
    step(1);  expect_all("ar_wait",       3'd1, 0, 0, 0, 0, 2'd0);
    step(1);  expect_all("ar_stable",     3'd2, 0, 0, 0, 0, 2'd0);
    step(8);  expect_all("ar_calib2",     3'd3, 0, 1, 0, 0, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
